// File: rtl/match_ctrl_if.sv
// match_ctrl_if: bundles the per-frame event inputs and the match outputs
// of match_ctrl. The controller connects through the slave modport; the
// surrounding ball/paddle logic or a test driver uses the master modport.
// Parameter: SCORE_W (width of each score bus).
//
// Signalling: there is no valid/ready pair here. frame_tick_i,
// miss_left_i and miss_right_i are single-cycle strobes that are always
// accepted (and simply ignored in states where they carry no meaning).
// start_i and pause_i are levels whose rising edge is the event. serve_o
// is a single-cycle strobe. Every other output is a registered level.
interface match_ctrl_if #(
    parameter int SCORE_W = 4
) ();

    // Event inputs into the controller
    logic               frame_tick_i;
    logic               start_i;
    logic               pause_i;
    logic               miss_left_i;
    logic               miss_right_i;

    // Registered outputs from the controller
    logic               ball_enable_o;
    logic               serve_o;
    logic               serve_dir_o;
    logic [SCORE_W-1:0] score_player_o;
    logic [SCORE_W-1:0] score_pc_o;
    logic               game_over_o;
    logic               winner_o;
    logic [2:0]         state_o;

    // Drives the events and observes the match state
    modport master (
        output frame_tick_i,
        output start_i,
        output pause_i,
        output miss_left_i,
        output miss_right_i,
        input  ball_enable_o,
        input  serve_o,
        input  serve_dir_o,
        input  score_player_o,
        input  score_pc_o,
        input  game_over_o,
        input  winner_o,
        input  state_o
    );

    // The match controller itself
    modport slave (
        input  frame_tick_i,
        input  start_i,
        input  pause_i,
        input  miss_left_i,
        input  miss_right_i,
        output ball_enable_o,
        output serve_o,
        output serve_dir_o,
        output score_player_o,
        output score_pc_o,
        output game_over_o,
        output winner_o,
        output state_o
    );

endinterface

// File: rtl/match_ctrl.sv
// match_ctrl: match-level sequencer for pong. It runs the
// IDLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER) flow, keeps both
// scores and gates the ball datapath through ball_enable_o, a one-cycle
// serve_o recentre/launch command and serve_dir_o.
//
// Optional feature macro: MATCH_PAUSE_EN adds a PAUSED state that is
// toggled from PLAY by rising edges of pause_i. Without the macro, the
// pause_i input is present on the interface but is ignored.
//
// All outputs are registered; reset is asynchronous and active-low.
module match_ctrl #(
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int DELAY_W      = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    match_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_POINT  = 3'd3,
        ST_OVER   = 3'd4
`ifdef MATCH_PAUSE_EN
        ,
        ST_PAUSED = 3'd5
`endif
    } state_t;

    localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
    localparam logic [DELAY_W-1:0] LOAD_VAL = DELAY_W'(SERVE_FRAMES);
    localparam logic [SCORE_W-1:0] SCORE_1  = SCORE_W'(1);
    localparam logic [DELAY_W-1:0] DELAY_1  = DELAY_W'(1);

    // ------------------------------------------------------------------
    // Key edge detection
    // ------------------------------------------------------------------
    logic start_q;
    logic start_prev_q;
    logic start_rise;

    // Register the start key once, then keep its previous value for the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            start_q      <= bus.start_i;
            start_prev_q <= start_q;
        end
    end

    assign start_rise = start_q & ~start_prev_q;

`ifdef MATCH_PAUSE_EN
    logic pause_q;
    logic pause_prev_q;
    logic pause_rise;

    // Register the pause key once, then keep its previous value for the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pause_q      <= 1'b0;
            pause_prev_q <= 1'b0;
        end else begin
            pause_q      <= bus.pause_i;
            pause_prev_q <= pause_q;
        end
    end

    assign pause_rise = pause_q & ~pause_prev_q;
`else
    // The key is still wired to the port but has no effect in this build.
    logic unused_pause;
    assign unused_pause = bus.pause_i;
`endif

    // ------------------------------------------------------------------
    // Match state and datapath registers
    // ------------------------------------------------------------------
    state_t               state_q,  state_d;
    logic [SCORE_W-1:0]   player_q, player_d;
    logic [SCORE_W-1:0]   pc_q,     pc_d;
    logic [DELAY_W-1:0]   delay_q,  delay_d;
    logic                 dir_q,    dir_d;
    logic                 winner_q, winner_d;
    logic                 serve_q,  serve_d;
    logic                 ball_en_q;
    logic                 over_q;
    // High during the first cycle spent in SERVE; a frame tick seen in that
    // cycle belongs to the previous phase and must not count.
    logic                 entry_q;

    // Next-state and next-output decode for the match flow.
    always_comb begin
        state_d  = state_q;
        player_d = player_q;
        pc_d     = pc_q;
        delay_d  = delay_q;
        dir_d    = dir_q;
        winner_d = winner_q;
        serve_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                player_d = '0;
                pc_d     = '0;
                if (start_rise) begin
                    state_d = ST_SERVE;
                    delay_d = LOAD_VAL;
                end
            end

            ST_SERVE: begin
                if (bus.frame_tick_i && !entry_q) begin
                    // Treat a (never expected) zero like one so the serve
                    // cannot stall forever.
                    if (delay_q <= DELAY_1) begin
                        state_d = ST_PLAY;
                        serve_d = 1'b1;
                        delay_d = '0;
                    end else begin
                        delay_d = delay_q - DELAY_1;
                    end
                end
            end

            ST_PLAY: begin
                // A left miss takes priority; a simultaneous right miss is dropped.
                if (bus.miss_left_i) begin
                    if (player_q != WIN_VAL) begin
                        player_d = player_q + SCORE_1;
                    end
                    dir_d   = 1'b0;
                    state_d = ST_POINT;
                end else if (bus.miss_right_i) begin
                    if (pc_q != WIN_VAL) begin
                        pc_d = pc_q + SCORE_1;
                    end
                    dir_d   = 1'b1;
                    state_d = ST_POINT;
                end
`ifdef MATCH_PAUSE_EN
                else if (pause_rise) begin
                    state_d = ST_PAUSED;
                end
`endif
            end

            ST_POINT: begin
                if ((player_q == WIN_VAL) || (pc_q == WIN_VAL)) begin
                    state_d  = ST_OVER;
                    winner_d = (player_q == WIN_VAL);
                end else begin
                    state_d = ST_SERVE;
                    delay_d = LOAD_VAL;
                end
            end

            ST_OVER: begin
                if (start_rise) begin
                    player_d = '0;
                    pc_d     = '0;
                    dir_d    = 1'b0;
                    state_d  = ST_SERVE;
                    delay_d  = LOAD_VAL;
                end
            end

`ifdef MATCH_PAUSE_EN
            ST_PAUSED: begin
                // Resume without a new serve; misses and ticks are ignored.
                if (pause_rise) begin
                    state_d = ST_PLAY;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register plus the registered outputs derived from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            player_q  <= '0;
            pc_q      <= '0;
            delay_q   <= '0;
            dir_q     <= 1'b0;
            winner_q  <= 1'b0;
            serve_q   <= 1'b0;
            ball_en_q <= 1'b0;
            over_q    <= 1'b0;
            entry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            player_q  <= player_d;
            pc_q      <= pc_d;
            delay_q   <= delay_d;
            dir_q     <= dir_d;
            winner_q  <= winner_d;
            serve_q   <= serve_d;
            ball_en_q <= (state_d == ST_PLAY);
            over_q    <= (state_d == ST_OVER);
            entry_q   <= (state_d == ST_SERVE) && (state_q != ST_SERVE);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ball_enable_o  = ball_en_q;
    assign bus.serve_o        = serve_q;
    assign bus.serve_dir_o    = dir_q;
    assign bus.score_player_o = player_q;
    assign bus.score_pc_o     = pc_q;
    assign bus.game_over_o    = over_q;
    assign bus.winner_o       = winner_q;
    assign bus.state_o        = state_q;

endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl: directed and randomised match sequences for match_ctrl.
// The reference model tracks the match at the level of rules: two integer
// scores, the last serve direction, the winner and the current phase, and
// predicts each visible output from those.
module tb_match_ctrl;

    localparam int SW  = 4;
    localparam int WIN = 2;
    localparam int SF  = 3;

    localparam int S_IDLE   = 0;
    localparam int S_SERVE  = 1;
    localparam int S_PLAY   = 2;
    localparam int S_POINT  = 3;
    localparam int S_OVER   = 4;
    localparam int S_PAUSED = 5;

    logic clk_i = 1'b0;
    logic rst_ni;

    match_ctrl_if #(.SCORE_W(SW)) bus ();

    match_ctrl #(
        .SCORE_W      (SW),
        .WIN_SCORE    (WIN),
        .SERVE_FRAMES (SF),
        .DELAY_W      (8)
    ) u_dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Counters and reference model
    int checks   = 0;
    int failures = 0;
    int m_player = 0;
    int m_pc     = 0;
    int m_dir    = 0;
    int m_winner = 0;
    int m_state  = S_IDLE;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare every output against the model for the expected state.
    task automatic check_outputs(input string tag, input int st, input int srv);
        check({tag, ".state"},  32'(bus.state_o), st);
        check({tag, ".en"},     32'(bus.ball_enable_o), (st == S_PLAY) ? 1 : 0);
        check({tag, ".serve"},  32'(bus.serve_o), srv);
        check({tag, ".over"},   32'(bus.game_over_o), (st == S_OVER) ? 1 : 0);
        check({tag, ".player"}, 32'(bus.score_player_o), m_player);
        check({tag, ".pc"},     32'(bus.score_pc_o), m_pc);
        check({tag, ".dir"},    32'(bus.serve_dir_o), m_dir);
        if (st == S_OVER) begin
            check({tag, ".winner"}, 32'(bus.winner_o), m_winner);
        end
    endtask

    task automatic model_reset();
        m_player = 0;
        m_pc     = 0;
        m_dir    = 0;
        m_winner = 0;
        m_state  = S_IDLE;
    endtask

    // Start key pulse from IDLE or OVER: SERVE two cycles after the edge.
    task automatic do_start(input string tag);
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        check_outputs({tag, ".t1"}, m_state, 0);
        step();
        m_player = 0;
        m_pc     = 0;
        m_dir    = 0;
        m_state  = S_SERVE;
        check_outputs({tag, ".t2"}, S_SERVE, 0);
    endtask

    // Runs SERVE from its entry cycle until the launch; stray misses and
    // start pulses are mixed in and must have no effect.
    task automatic do_serve(input string tag, input bit tick_on_entry);
        int counted = 0;
        int cyc = 0;
        bit t;
        bus.frame_tick_i = tick_on_entry;
        step();
        bus.frame_tick_i = 1'b0;
        check_outputs({tag, ".entry"}, S_SERVE, 0);
        while (counted < SF && cyc < 200) begin
            t = ($urandom_range(0, 2) == 0) || (cyc > 50);
            bus.frame_tick_i = t;
            bus.miss_left_i  = ($urandom_range(0, 7) == 0);
            bus.miss_right_i = ($urandom_range(0, 7) == 0);
            bus.start_i      = ($urandom_range(0, 7) == 0);
            step();
            bus.frame_tick_i = 1'b0;
            bus.miss_left_i  = 1'b0;
            bus.miss_right_i = 1'b0;
            bus.start_i      = 1'b0;
            if (t) counted++;
            if (counted < SF) begin
                check_outputs({tag, ".wait"}, S_SERVE, 0);
            end else begin
                m_state = S_PLAY;
                check_outputs({tag, ".launch"}, S_PLAY, 1);
            end
            cyc++;
        end
        if (counted < SF) begin
            check({tag, ".serve_timeout"}, 32'(bus.state_o), S_PLAY);
        end
        step();
        check_outputs({tag, ".play"}, S_PLAY, 0);
    endtask

    // From PLAY: some idle rally cycles, then a miss (0 left, 1 right, 2 both).
    task automatic do_point(input string tag, input int kind);
        int idle = $urandom_range(0, 4);
        for (int i = 0; i < idle; i++) begin
            bus.frame_tick_i = ($urandom_range(0, 1) == 0);
            step();
            bus.frame_tick_i = 1'b0;
            check_outputs({tag, ".rally"}, S_PLAY, 0);
        end
        bus.miss_left_i  = (kind == 0 || kind == 2);
        bus.miss_right_i = (kind == 1 || kind == 2);
        step();
        bus.miss_left_i  = 1'b0;
        bus.miss_right_i = 1'b0;
        if (kind != 1) begin
            if (m_player < WIN) m_player++;
            m_dir = 0;
        end else begin
            if (m_pc < WIN) m_pc++;
            m_dir = 1;
        end
        check_outputs({tag, ".point"}, S_POINT, 0);
        step();
        if (m_player == WIN || m_pc == WIN) begin
            m_winner = (m_player == WIN) ? 1 : 0;
            m_state  = S_OVER;
        end else begin
            m_state = S_SERVE;
        end
        check_outputs({tag, ".after"}, m_state, 0);
    endtask

    // Drive the stimulus and report
    initial begin
        bus.frame_tick_i = 1'b0;
        bus.start_i      = 1'b0;
        bus.pause_i      = 1'b0;
        bus.miss_left_i  = 1'b0;
        bus.miss_right_i = 1'b0;
        rst_ni           = 1'b0;
        model_reset();

        #22;
        check_outputs("reset_hold", S_IDLE, 0);
        #1 rst_ni = 1'b1;
        step();
        check_outputs("reset_release", S_IDLE, 0);

        // Misses in IDLE are ignored
        bus.miss_left_i  = 1'b1;
        bus.miss_right_i = 1'b1;
        step();
        bus.miss_left_i  = 1'b0;
        bus.miss_right_i = 1'b0;
        check_outputs("idle_miss", S_IDLE, 0);

        // First match: left point, then simultaneous misses wins for player
        do_start("start1");
        do_serve("serve1", 1'b1);
        do_point("left1", 0);
        do_serve("serve2", 1'b0);
        do_point("both", 2);

        // Misses in OVER leave the frozen scores alone
        bus.miss_left_i = 1'b1;
        step();
        bus.miss_left_i  = 1'b0;
        bus.miss_right_i = 1'b1;
        step();
        bus.miss_right_i = 1'b0;
        check_outputs("over_miss", S_OVER, 0);

        // Restart from OVER, then the PC takes two points
        do_start("restart1");
        do_serve("serve3", 1'b1);
        do_point("right1", 1);
        do_serve("serve4", 1'b0);
        do_point("right2", 1);
        do_start("restart2");

`ifdef MATCH_PAUSE_EN
        // Pause in PLAY, ignore a miss, then resume without a serve
        do_serve("serve_p", 1'b0);
        bus.pause_i = 1'b1;
        step();
        bus.pause_i = 1'b0;
        check_outputs("pause.t1", S_PLAY, 0);
        step();
        check_outputs("pause.t2", S_PAUSED, 0);
        bus.miss_left_i  = 1'b1;
        bus.frame_tick_i = 1'b1;
        step();
        bus.miss_left_i  = 1'b0;
        bus.frame_tick_i = 1'b0;
        check_outputs("pause.miss", S_PAUSED, 0);
        bus.pause_i = 1'b1;
        step();
        bus.pause_i = 1'b0;
        check_outputs("resume.t1", S_PAUSED, 0);
        step();
        check_outputs("resume.t2", S_PLAY, 0);
        do_point("pause_pt", 0);
`endif

        // Asynchronous reset in the middle of SERVE, between clock edges
        if (m_state != S_SERVE) begin
            if (m_state == S_OVER) do_start("pre_rst");
        end
        step();
        check_outputs("pre_rst_serve", m_state, 0);
        #3 rst_ni = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst", S_IDLE, 0);
        #2 rst_ni = 1'b1;
        step();
        check_outputs("post_rst", S_IDLE, 0);

        // Random matches against the model
        for (int g = 0; g < 4; g++) begin
            do_start("rnd_start");
            for (int r = 0; r < 20 && m_state != S_OVER; r++) begin
                do_serve("rnd_serve", 1'($urandom_range(0, 1)));
                do_point("rnd_point", $urandom_range(0, 2));
            end
            check("rnd_match_end", 32'(bus.game_over_o), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/match_ctrl.md
# match_ctrl

Match-level sequencer for the pong game. It owns the serve / play / point / game-over flow, keeps both scores, and gates the ball datapath through `ball_enable_o`, a one-cycle `serve_o` recentre command and `serve_dir_o`. It sits between the per-frame ball/paddle update logic and the keys: the frame-change pulse and the ball-exit detection come in, and the enable, serve and score signals go out.

## Interface
- `SCORE_W`, 4: width of each score counter.
- `WIN_SCORE`, 7: points needed to win. Must satisfy 1 ≤ WIN_SCORE ≤ 2^SCORE_W − 1.
- `SERVE_FRAMES`, 60: frame ticks between entering SERVE and the serve. Must be ≥ 1.
- `DELAY_W`, 8: width of the serve-delay counter. Must satisfy SERVE_FRAMES < 2^DELAY_W.
- `clk_i` input 1: the single clock.
- `rst_ni` input 1: asynchronous, active-low reset.
- `frame_tick_i` input 1: one-cycle pulse per video frame.
- `start_i` input 1: start key, level. Only its rising edge is used.
- `pause_i` input 1: pause key, level. Only its rising edge is used, and only when `MATCH_PAUSE_EN` is defined.
- `miss_left_i` input 1: ball left the screen on the PC side, so the player scores. Single-cycle pulse.
- `miss_right_i` input 1: ball left the screen on the player side, so the PC scores. Single-cycle pulse.
- `ball_enable_o` output 1: ball motion allowed.
- `serve_o` output 1: one-cycle command to recentre the ball and launch it.
- `serve_dir_o` output 1: launch direction. 1 = toward the player (ball x decreasing is 0).
- `score_player_o` output SCORE_W: player score.
- `score_pc_o` output SCORE_W: PC score.
- `game_over_o` output 1: match finished.
- `winner_o` output 1: 1 = player won. Valid only while `game_over_o` = 1.
- `state_o` output 3: current state encoding, for debug and LEDs.

## Operation
- States and encodings:
  - IDLE = 0
  - SERVE = 1
  - PLAY = 2
  - POINT = 3
  - OVER = 4
  - PAUSED = 5 (exists only when `MATCH_PAUSE_EN` is defined)
- `start_i` and `pause_i` are registered once and edge-detected internally. `start_rise` is high for one cycle after a 0→1 transition.
- IDLE:
  - Scores are held at 0 and `ball_enable_o` = 0.
  - `start_rise` → SERVE, with the delay counter loaded to SERVE_FRAMES.
- SERVE:
  - `ball_enable_o` = 0.
  - Each `frame_tick_i` decrements the delay counter.
  - A tick that arrives with the counter = 1 → PLAY, and `serve_o` = 1 on the first PLAY cycle.
- PLAY:
  - `ball_enable_o` = 1.
  - `miss_left_i` → player score +1, `serve_dir_o` ← 0, then → POINT.
  - `miss_right_i` → PC score +1, `serve_dir_o` ← 1, then → POINT.
  - If both misses arrive in the same cycle, `miss_left_i` wins and `miss_right_i` is dropped.
- POINT (always one cycle):
  - `ball_enable_o` = 0.
  - If either score equals WIN_SCORE → OVER, with `winner_o` ← (player score == WIN_SCORE).
  - Otherwise → SERVE, with the delay counter reloaded.
- OVER:
  - `game_over_o` = 1, `ball_enable_o` = 0, and scores are frozen.
  - `start_rise` → both scores cleared, `serve_dir_o` ← 0, then → SERVE.
- Misses outside PLAY are ignored.
- `start_rise` in SERVE, PLAY or POINT is ignored.
- Scores never wrap, because the counter stops at WIN_SCORE.
- `serve_dir_o` keeps its value until the next point or restart.

## Timing
- All outputs are registered. Reset values:
  - state IDLE
  - scores 0
  - `ball_enable_o` 0
  - `serve_o` 0
  - `serve_dir_o` 0
  - `game_over_o` 0
  - `winner_o` 0
  - delay counter 0
- Key to state:
  - A `start_i` rising edge at cycle t gives `start_rise` at t+1 and SERVE visible at t+2.
- Serve timing:
  - `serve_o` rises on the cycle after the SERVE_FRAMES-th frame tick counted in SERVE.
  - `serve_o` is exactly one cycle wide and coincides with the first `ball_enable_o` = 1 cycle.
- Miss handling:
  - A miss at cycle t gives the updated score, POINT and `ball_enable_o` = 0 at t+1.
  - At t+2 the block is in SERVE or OVER.
- A frame tick on the state-entry cycle of SERVE is not counted.
- Reset asserted mid-operation forces all reset values immediately, without waiting for a clock. Release is synchronised externally.

## Configuration
- `MATCH_PAUSE_EN` defined:
  - In PLAY, `pause_rise` → PAUSED with `ball_enable_o` = 0.
  - In PAUSED, `pause_rise` → PLAY with no serve.
  - Misses and frame ticks are ignored in PAUSED.
  - In SERVE, `pause_rise` is ignored.
- `MATCH_PAUSE_EN` undefined:
  - The PAUSED state and the pause edge detector are not compiled.
  - The `pause_i` port stays present and is ignored.

## Test plan
- Reset with SERVE_FRAMES=3, then pulse `start_i` → SERVE two cycles later. `serve_o` is a single pulse and `ball_enable_o` = 1 on the cycle after the 3rd frame tick.
- In PLAY, pulse `miss_left_i` → `score_player_o` = 1, POINT for one cycle, back to SERVE, and `serve_dir_o` = 0.
- With WIN_SCORE=2, give two `miss_right_i` points → `game_over_o` = 1, `winner_o` = 0, scores 0/2. Then `start_i` → scores 0/0 and SERVE.
- Assert `miss_left_i` and `miss_right_i` in the same PLAY cycle → player +1, PC unchanged. A miss in SERVE or IDLE → no score change.
- Drop `rst_ni` mid-SERVE and between clock edges → all outputs at reset values immediately, state IDLE.
- With `MATCH_PAUSE_EN`: pause in PLAY → `ball_enable_o` = 0 and misses ignored; pause again → PLAY with no `serve_o`.
